// File: rtl/usb2phy_pkg.sv
// Shared definitions for the USB 2.0 PHY receive path: HS stuffing length,
// idle line level and the NRZI receiver state encoding.
package usb2phy_pkg;

    localparam int   STUFF_LEN_HS = 6;
    localparam logic LINE_J       = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } nrzi_rx_state_t;

    // NRZI: an unchanged line level decodes to 1, a transition decodes to 0.
    function automatic logic nrzi_decode(input logic level, input logic prev_level);
        return ~(level ^ prev_level);
    endfunction

endpackage

// File: rtl/bit_unstuffer.sv
// Counts consecutive decoded ones, drops the stuffed zero that follows a full
// run and flags a one in that position as a stuff violation.
module bit_unstuffer
    import usb2phy_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_HS,
    parameter int CNT_W     = $clog2(STUFF_LEN + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_in,
    input  logic bit_valid,
    output logic data,
    output logic data_valid,
    output logic err
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);

    logic [CNT_W-1:0] ones_cnt_reg;
    logic [CNT_W-1:0] ones_cnt_next;

    always_comb begin
        ones_cnt_next = ones_cnt_reg;
        data          = bit_in;
        data_valid    = 1'b0;
        err           = 1'b0;
        if (clear) begin
            ones_cnt_next = '0;
        end else if (bit_valid) begin
            if (ones_cnt_reg == RUN_MAX) begin
                // Stuff position: a zero is silently dropped, a one is a violation.
                ones_cnt_next = '0;
                err           = bit_in;
            end else if (bit_in) begin
                ones_cnt_next = ones_cnt_reg + CNT_W'(1);
                data_valid    = 1'b1;
            end else begin
                ones_cnt_next = '0;
                data_valid    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt_reg <= '0;
        end else begin
            ones_cnt_reg <= ones_cnt_next;
        end
    end

endmodule

// File: rtl/nrzi_decoder.sv
// HS receive-path NRZI decoder: line levels to data bits with bit unstuffing;
// the stuff-violation pulse doubles as the HS EOP indication.
module nrzi_decoder
    import usb2phy_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_HS
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic din_valid,
    input  logic rx_active,
    output logic dout,
    output logic dout_valid,
    output logic stuff_err
);

    nrzi_rx_state_t state_reg;
    nrzi_rx_state_t state_next;
    logic           prev_level_reg;
    logic           prev_level_next;
    logic           dout_reg;
    logic           dout_next;
    logic           dout_valid_reg;
    logic           stuff_err_reg;

    logic accept;
    logic decoded;
    logic us_clear;
    logic us_data;
    logic us_valid;
    logic us_err;

    // IDLE accepts the sample on the edge that starts the packet, so only ERR blocks.
    assign accept  = din_valid & rx_active & (state_reg != ERR);
    assign decoded = nrzi_decode(din, prev_level_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (rx_active) state_next = RUN;
            RUN: begin
                // Envelope end wins over a violation on the same edge.
                if (!rx_active)  state_next = IDLE;
                else if (us_err) state_next = ERR;
            end
            ERR:  if (!rx_active) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prev_level_next = prev_level_reg;
        if (state_next == IDLE) begin
            prev_level_next = LINE_J;
        end else if (accept) begin
            prev_level_next = din;
        end
    end

    assign us_clear  = (state_next == IDLE);
    assign dout_next = us_valid ? us_data : dout_reg;

    bit_unstuffer #(
        .STUFF_LEN (STUFF_LEN)
    ) u_unstuffer (
        .clk        (clk),
        .rst        (rst),
        .clear      (us_clear),
        .bit_in     (decoded),
        .bit_valid  (accept),
        .data       (us_data),
        .data_valid (us_valid),
        .err        (us_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            prev_level_reg <= LINE_J;
            dout_reg       <= 1'b0;
            dout_valid_reg <= 1'b0;
            stuff_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prev_level_reg <= prev_level_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= us_valid;
            stuff_err_reg  <= us_err;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign stuff_err  = stuff_err_reg;

endmodule

// File: tb/tb_nrzi_decoder.sv
// Randomized and directed bench for nrzi_decoder against a behavioural model
// of the line coding and stuffing rules.
module tb_nrzi_decoder;

    logic clk;
    logic rst;
    logic din;
    logic din_valid;
    logic rx_active;
    logic dout;
    logic dout_valid;
    logic stuff_err;

    int checks   = 0;
    int failures = 0;

    // Model state: last line level seen, length of the current run of ones,
    // whether the packet has been killed by a violation, and held output.
    logic m_prev;
    int   m_ones;
    bit   m_dead;
    logic exp_dout;
    logic exp_valid;
    logic exp_err;

    // Line level the bench is currently driving (to build levels from bits).
    logic lvl;

    nrzi_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .rx_active  (rx_active),
        .dout       (dout),
        .dout_valid (dout_valid),
        .stuff_err  (stuff_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev    = 1'b1;
        m_ones    = 0;
        m_dead    = 0;
        exp_dout  = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic model_edge(input logic d, input logic v, input logic a);
        logic b;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (!a) begin
            m_prev = 1'b1;
            m_ones = 0;
            m_dead = 0;
        end else if (v && !m_dead) begin
            b      = (d == m_prev);
            m_prev = d;
            if (m_ones == 6) begin
                m_ones = 0;
                if (b) begin
                    exp_err = 1'b1;
                    m_dead  = 1;
                end
            end else begin
                m_ones    = b ? m_ones + 1 : 0;
                exp_valid = 1'b1;
                exp_dout  = b;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("dout_valid", dout_valid, exp_valid);
        check_eq("stuff_err", stuff_err, exp_err);
        check_eq("dout", dout, exp_dout);
    endtask

    // One clock: drive at negedge, model the edge, check just after it.
    task automatic step(input logic d, input logic v, input logic a);
        din       = d;
        din_valid = v;
        rx_active = a;
        @(posedge clk);
        model_edge(d, v, a);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        lvl = b ? lvl : ~lvl;
        step(lvl, 1'b1, 1'b1);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(lvl, 1'b0, 1'b1);
    endtask

    task automatic end_pkt();
        step(lvl, 1'b0, 1'b0);
        step(lvl, 1'b0, 1'b0);
        lvl = 1'b1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        lvl = 1'b1;
    endtask

    initial begin
        int plen;
        rst       = 1'b1;
        din       = 1'b1;
        din_valid = 1'b0;
        rx_active = 1'b0;
        lvl       = 1'b1;
        model_reset();

        // 1: reset held for 4 cycles, then a J sample decodes to 1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b0;
        send_bit(1'b1);
        check_eq("first_bit_valid", dout_valid, 1'b1);
        check_eq("first_bit_one", dout, 1'b1);
        end_pkt();
        $display("txn reset_and_first_bit done");

        // 2: levels 0,0,1,1,0 -> 0,1,0,1,0
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_eq("levels_last_zero", dout, 1'b0);
        end_pkt();
        $display("txn level_sequence done");

        // 3: six ones, stuffed zero dropped, then a one
        send_bits(32'b11111101, 8);
        check_eq("post_stuff_one", dout, 1'b1);
        end_pkt();
        $display("txn stuff_drop done");

        // 4: seven ones -> violation, packet dead until envelope ends
        send_bits(32'b1111111, 7);
        check_eq("violation_pulse", stuff_err, 1'b1);
        send_bits(32'b0101, 4);
        end_pkt();
        send_bits(32'b1001, 4);
        end_pkt();
        $display("txn stuff_violation done");

        // 5: run of ones spans a din_valid gap
        send_bits(32'b111, 3);
        gap(2);
        send_bits(32'b1110, 4);
        check_eq("gap_stuff_dropped", dout_valid, 1'b0);
        end_pkt();
        $display("txn gap_run done");

        // 6: envelope drop with line at K, and reset mid-packet
        send_bit(1'b0);
        step(lvl, 1'b1, 1'b0);
        step(lvl, 1'b0, 1'b0);
        lvl = 1'b1;
        send_bit(1'b1);
        check_eq("after_drop_one", dout, 1'b1);
        send_bits(32'b0111, 4);
        pulse_reset();
        send_bit(1'b1);
        check_eq("after_rst_one", dout, 1'b1);
        end_pkt();
        $display("txn return_to_j done");

        // Random packets: biased toward ones to exercise stuffing and EOP
        for (int p = 0; p < 60; p++) begin
            plen = $urandom_range(8, 60);
            for (int i = 0; i < plen; i++) begin
                if ($urandom_range(0, 99) < 15) begin
                    gap(1);
                end else begin
                    send_bit(($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0);
                end
                if ($urandom_range(0, 299) == 0) pulse_reset();
            end
            if ($urandom_range(0, 3) == 0) begin
                lvl = $urandom_range(0, 1) != 0;
                step(lvl, 1'b1, 1'b0);
            end
            end_pkt();
            $display("txn random_packet %0d len=%0d checks=%0d", p, plen, checks);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
